// File: rtl/pc_fetch_unit_pkg.sv
// Shared codes and constants for the fetch unit and the ID decoder.
// Branch/jump class encodings, reset PC default, NOP word.
package pc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_IMM  = 2'd1,
    JMP_REG  = 2'd2,
    JMP_RSVD = 2'd3
  } jmp_type_e;

  typedef struct packed {
    logic eq;
    logic ne;
    logic lez;
    logic gez;
    logic gtz;
    logic ltz;
  } br_flags_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/pc_npc_sel.sv
// Branch condition select and next-PC mux for the fetch stage.
// In: pc_if, IF/ID pc/instr, class codes, flags, jr target. Out: npc, taken, is_ctl.
module pc_npc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc_if,
  input  logic [31:0] i_pc_id,
  input  logic [31:0] i_instr_id,
  input  logic [2:0]  i_br_type,
  input  logic [1:0]  i_jmp_type,
  input  br_flags_t   i_flags,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_npc,
  output logic        o_br_taken,
  output logic        o_is_ctl
);

  logic        w_cond;
  logic        w_j_imm;
  logic        w_j_reg;
  logic        w_br_sel;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_unused;

  always_comb begin
    w_cond = 1'b0;
    unique case (1'b1)
      (i_br_type == BR_BEQ):  w_cond = i_flags.eq;
      (i_br_type == BR_BNE):  w_cond = i_flags.ne;
      (i_br_type == BR_BLEZ): w_cond = i_flags.lez;
      (i_br_type == BR_BGTZ): w_cond = i_flags.gtz;
      (i_br_type == BR_BLTZ): w_cond = i_flags.ltz;
      (i_br_type == BR_BGEZ): w_cond = i_flags.gez;
      default:                w_cond = 1'b0;
    endcase
  end

  assign w_j_imm  = (i_jmp_type == JMP_IMM);
  assign w_j_reg  = (i_jmp_type == JMP_REG);
  // jump beats a simultaneous branch, so mask the branch select
  assign w_br_sel = w_cond & ~(w_j_imm | w_j_reg);

  assign w_br_tgt = i_pc_id + 32'd4
                  + {{14{i_instr_id[15]}}, i_instr_id[15:0], 2'b00};
  assign w_j_tgt  = {i_pc_id[31:28], i_instr_id[25:0], 2'b00};

  always_comb begin
    o_npc = i_pc_if + 32'd4;
    unique case (1'b1)
      w_j_imm:  o_npc = w_j_tgt;
      w_j_reg:  o_npc = i_jr_target;
      w_br_sel: o_npc = w_br_tgt;
      default:  o_npc = i_pc_if + 32'd4;
    endcase
  end

  assign o_br_taken = w_cond | w_j_imm | w_j_reg;
  assign o_is_ctl   = (i_br_type != BR_NONE && i_br_type != BR_RSVD)
                    | w_j_imm | w_j_reg;

  assign w_unused = ^i_instr_id[31:26];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, IF/ID register and optional branch statistics.
// Macro PC_FETCH_BRSTAT_EN enables br_count/br_taken_count; else they read 0.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_if,
  input  logic [2:0]  br_type,
  input  logic [1:0]  jmp_type,
  input  logic        f_eq,
  input  logic        f_ne,
  input  logic        f_lez,
  input  logic        f_gez,
  input  logic        f_gtz,
  input  logic        f_ltz,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc8_id,
  output logic        br_taken,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  logic [31:0] r_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc8_id;
  logic [31:0] w_npc;
  logic        w_br_taken;
  logic        w_is_ctl;
  br_flags_t   w_flags;

  assign w_flags = '{eq: f_eq, ne: f_ne, lez: f_lez,
                     gez: f_gez, gtz: f_gtz, ltz: f_ltz};

  pc_npc_sel u_sel (
    .i_pc_if     (r_pc),
    .i_pc_id     (r_pc_id),
    .i_instr_id  (r_instr_id),
    .i_br_type   (br_type),
    .i_jmp_type  (jmp_type),
    .i_flags     (w_flags),
    .i_jr_target (jr_target),
    .o_npc       (w_npc),
    .o_br_taken  (w_br_taken),
    .o_is_ctl    (w_is_ctl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr_id <= NOP_WORD;
      r_pc_id    <= RESET_PC;
      r_pc8_id   <= RESET_PC + 32'd8;
    end else if (!stall) begin
      r_pc       <= w_npc;
      r_instr_id <= instr_if;
      r_pc_id    <= r_pc;
      r_pc8_id   <= r_pc + 32'd8;
    end
  end

  assign pc_if    = r_pc;
  assign instr_id = r_instr_id;
  assign pc_id    = r_pc_id;
  assign pc8_id   = r_pc8_id;
  assign br_taken = w_br_taken;

`ifdef PC_FETCH_BRSTAT_EN
  logic [31:0] r_br_count;
  logic [31:0] r_br_taken_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_count       <= 32'h0;
      r_br_taken_count <= 32'h0;
    end else if (!stall && w_is_ctl) begin
      r_br_count <= r_br_count + 32'd1;
      if (w_br_taken) begin
        r_br_taken_count <= r_br_taken_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall && (w_npc < IM_BASE)) begin
      $display("pc_fetch_unit: npc %h below IM_BASE %h", w_npc, IM_BASE);
    end
  end

  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
`else
  logic w_unused;
  assign w_unused       = ^{IM_BASE, w_is_ctl};
  assign br_count       = 32'h0;
  assign br_taken_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a reference model of fetch.
// Compare process at negedge; literal checks pin the model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instr_if;
  logic [2:0]  br_type = 3'd0;
  logic [1:0]  jmp_type = 2'd0;
  logic        f_eq = 1'b0, f_ne = 1'b0, f_lez = 1'b0;
  logic        f_gez = 1'b0, f_gtz = 1'b0, f_ltz = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] pc_if, instr_id, pc_id, pc8_id;
  logic        br_taken;
  logic [31:0] br_count, br_taken_count;

  int total = 0;
  int bad = 0;

  localparam logic [5:0] EQ  = 6'b100000;
  localparam logic [5:0] NE  = 6'b010000;
  localparam logic [5:0] GTZ = 6'b000010;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .instr_if       (instr_if),
    .br_type        (br_type),
    .jmp_type       (jmp_type),
    .f_eq           (f_eq),
    .f_ne           (f_ne),
    .f_lez          (f_lez),
    .f_gez          (f_gez),
    .f_gtz          (f_gtz),
    .f_ltz          (f_ltz),
    .jr_target      (jr_target),
    .pc_if          (pc_if),
    .instr_id       (instr_id),
    .pc_id          (pc_id),
    .pc8_id         (pc8_id),
    .br_taken       (br_taken),
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'h0000};
  endfunction

  assign instr_if = rd(pc_if);

  // reference state
  logic [31:0] m_pc, m_iid, m_pcid, m_pc8, m_bc, m_btc;
  bit m_ok = 0;

  function automatic logic m_cond();
    case (br_type)
      3'd1: return f_eq;
      3'd2: return f_ne;
      3'd3: return f_lez;
      3'd4: return f_gtz;
      3'd5: return f_ltz;
      3'd6: return f_gez;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_jump();
    return (jmp_type == 2'd1) || (jmp_type == 2'd2);
  endfunction

  function automatic logic m_taken();
    return m_cond() || m_jump();
  endfunction

  function automatic logic [31:0] m_next();
    int off;
    if (jmp_type == 2'd1)
      return {m_pcid[31:28], m_iid[25:0], 2'b00};
    if (jmp_type == 2'd2)
      return jr_target;
    if (m_cond()) begin
      off = int'($signed(m_iid[15:0])) * 4;
      return m_pcid + 32'd4 + 32'(off);
    end
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    logic [31:0] n;
    if (reset) begin
      m_pc = 32'h3000;
      m_iid = 32'h0;
      m_pcid = 32'h3000;
      m_pc8 = 32'h3008;
      m_bc = 0;
      m_btc = 0;
      m_ok = 1;
    end else if (!stall && m_ok) begin
      if ((br_type >= 3'd1 && br_type <= 3'd6) || m_jump()) begin
        m_bc = m_bc + 1;
        if (m_taken()) m_btc = m_btc + 1;
      end
      n = m_next();
      m_pc8 = m_pc + 32'd8;
      m_pcid = m_pc;
      m_iid = rd(m_pc);
      m_pc = n;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m.pc_if", pc_if, m_pc);
      chk("m.instr_id", instr_id, m_iid);
      chk("m.pc_id", pc_id, m_pcid);
      chk("m.pc8_id", pc8_id, m_pc8);
      chk("m.br_taken", {31'b0, br_taken}, {31'b0, m_taken()});
`ifdef PC_FETCH_BRSTAT_EN
      chk("m.br_count", br_count, m_bc);
      chk("m.br_taken_count", br_taken_count, m_btc);
`else
      chk("m.br_count", br_count, 32'h0);
      chk("m.br_taken_count", br_taken_count, 32'h0);
`endif
    end
  end

  task automatic ctl(input logic [2:0] b, input logic [1:0] j,
                     input logic [5:0] f);
    br_type = b;
    jmp_type = j;
    {f_eq, f_ne, f_lez, f_gez, f_gtz, f_ltz} = f;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // flag index (bit of EQ..LTZ vector) selected by each br_type
  int flag_of [8] = '{-1, 5, 4, 3, 1, 0, 2, -1};

  initial begin
    mem[32'h3004] = 32'h1000_FFFF;
    mem[32'h3008] = 32'h1400_0010;
    mem[32'h300C] = 32'h1C00_0004;
    mem[32'h3010] = 32'h0C00_0C40;

    reset = 1;
    cyc();
    cyc();
    chk("rst.pc_if", pc_if, 32'h3000);
    chk("rst.instr_id", instr_id, 32'h0);
    chk("rst.pc_id", pc_id, 32'h3000);
    chk("rst.pc8_id", pc8_id, 32'h3008);
    reset = 0;

    cyc();
    chk("run.pc_if1", pc_if, 32'h3004);
    chk("run.instr_id1", instr_id, 32'h3000_0000);
    cyc();
    chk("run.pc_if2", pc_if, 32'h3008);
    chk("run.instr_id2", instr_id, 32'h1000_FFFF);
    chk("run.pc8_id2", pc8_id, 32'h300C);

    ctl(3'd1, 2'd0, EQ);
    #1;
    chk("beq.taken", {31'b0, br_taken}, 32'h1);
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("beq.pc_if", pc_if, 32'h3004);
    chk("beq.slot", instr_id, 32'h1400_0010);
    chk("beq.slot_pc", pc_id, 32'h3008);

    ctl(3'd2, 2'd0, 6'h0);
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("bne_nt.pc_if", pc_if, 32'h3008);
    cyc();
    chk("bne.pc_id", pc_id, 32'h3008);
    ctl(3'd2, 2'd0, NE);
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("bne_t.pc_if", pc_if, 32'h304C);

    ctl(3'd4, 2'd0, GTZ);
    stall = 1;
    cyc();
    chk("stall1.pc_if", pc_if, 32'h304C);
    chk("stall1.instr_id", instr_id, 32'h1C00_0004);
    cyc();
    chk("stall2.pc_if", pc_if, 32'h304C);
    chk("stall2.instr_id", instr_id, 32'h1C00_0004);
    stall = 0;
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("bgtz.pc_if", pc_if, 32'h3020);
    cyc();
    chk("bgtz.once", pc_if, 32'h3024);
    chk("bgtz.pc_id", pc_id, 32'h3020);

    ctl(3'd0, 2'd2, 6'h0);
    jr_target = 32'h3010;
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("jr1.pc_if", pc_if, 32'h3010);
    cyc();
    chk("jal.pc_id", pc_id, 32'h3010);
    chk("jal.pc8_id", pc8_id, 32'h3018);
    ctl(3'd1, 2'd1, EQ);
    #1;
    chk("jal.taken", {31'b0, br_taken}, 32'h1);
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("jal.pc_if", pc_if, 32'h3100);

    ctl(3'd0, 2'd2, 6'h0);
    jr_target = 32'h3020;
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("jr2.pc_if", pc_if, 32'h3020);

    ctl(3'd0, 2'd2, 6'h0);
    jr_target = 32'hFFFF_FFFC;
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("wrap.pc_if0", pc_if, 32'hFFFF_FFFC);
    cyc();
    chk("wrap.pc_if1", pc_if, 32'h0);
    chk("wrap.pc8_id", pc8_id, 32'h4);

    ctl(3'd7, 2'd3, 6'h3F);
    #1;
    chk("rsvd.taken", {31'b0, br_taken}, 32'h0);
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
    chk("rsvd.pc_if", pc_if, 32'h4);

    stall = 1;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 6; k++) begin
        ctl(3'(b), 2'd0, 6'(1) << k);
        #1;
        chk("cond.taken", {31'b0, br_taken},
            {31'b0, (flag_of[b] == k)});
      end
    end
    ctl(3'd0, 2'd0, 6'h0);
    chk("cond.hold", pc_if, 32'h4);

    ctl(3'd1, 2'd1, EQ);
    reset = 1;
    cyc();
    chk("rst2.pc_if", pc_if, 32'h3000);
    chk("rst2.instr_id", instr_id, 32'h0);
    chk("rst2.pc_id", pc_id, 32'h3000);
    chk("rst2.pc8_id", pc8_id, 32'h3008);
    reset = 0;
    stall = 0;
    ctl(3'd0, 2'd0, 6'h0);

    ctl(3'd1, 2'd0, EQ);
    cyc();
    stall = 1;
    cyc();
    stall = 0;
    cyc();
    ctl(3'd2, 2'd0, 6'h0);
    cyc();
    ctl(3'd0, 2'd2, 6'h0);
    jr_target = 32'h3000;
    cyc();
    ctl(3'd0, 2'd0, 6'h0);
`ifdef PC_FETCH_BRSTAT_EN
    chk("stat.br_count", br_count, 32'd4);
    chk("stat.br_taken_count", br_taken_count, 32'd3);
`else
    chk("stat.br_count", br_count, 32'd0);
    chk("stat.br_taken_count", br_taken_count, 32'd0);
`endif
    chk("stat.pc_if", pc_if, 32'h3000);

    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
